// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: round-robin write-back arbiter feeding the register file's
// single write port through a registered output stage.
module regfile_wb_arbiter #(
    parameter int NREQ = 3,
    parameter int GW = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*5-1:0] req_rd,
    input  logic [NREQ*32-1:0] req_wd,
    output logic [NREQ-1:0]   req_ready,
    input  logic              wb_stall,
    output logic              RegWrite,
    output logic [4:0]        rd,
    output logic [31:0]       wd,
    output logic [GW-1:0]     grant_id,
    output logic              busy
);
    logic [GW-1:0] ptr, win;
    logic [GW:0]   idx;
    logic          hit;
    logic [4:0]    sel_rd;
    logic [31:0]   sel_wd;
    always_comb begin
        win = '0;
        hit = 1'b0;
        idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = {1'b0, ptr} + (GW+1)'(k);
            idx = (idx >= (GW+1)'(NREQ)) ? idx - (GW+1)'(NREQ) : idx;
            if (!hit && !rst && !wb_stall && req_valid[idx[GW-1:0]]) begin
                win = idx[GW-1:0];
                hit = 1'b1;
            end
        end
    end
    assign req_ready = hit ? NREQ'(1) << win : '0;
    assign sel_rd    = req_rd[5*win +: 5];
    assign sel_wd    = req_wd[32*win +: 32];
    assign busy      = |req_valid && !wb_stall && !rst;
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr      <= '0;
            RegWrite <= 1'b0;
            rd       <= '0;
            wd       <= '0;
            grant_id <= '0;
        end else begin
            RegWrite <= hit && (sel_rd != 5'd0);
            if (hit) begin
                ptr      <= (win == GW'(NREQ-1)) ? '0 : win + 1'b1;
                rd       <= sel_rd;
                wd       <= sel_wd;
                grant_id <= win;
            end
        end
    end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed vectors for the write-back arbiter with a small
// register-file model fed from the write port.
module tb_regfile_wb_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  req_valid;
    logic [14:0] req_rd;
    logic [95:0] req_wd;
    logic [2:0]  req_ready;
    logic        wb_stall;
    logic        RegWrite;
    logic [4:0]  rd;
    logic [31:0] wd;
    logic [1:0]  grant_id;
    logic        busy;
    logic [31:0] regs [32];
    int checks = 0;
    int errors = 0;

    regfile_wb_arbiter #(.NREQ(3)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_rd(req_rd),
        .req_wd(req_wd), .req_ready(req_ready), .wb_stall(wb_stall),
        .RegWrite(RegWrite), .rd(rd), .wd(wd), .grant_id(grant_id), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        if (RegWrite && rd != 5'd0) regs[rd] <= wd;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [4:0] r, input logic [31:0] d);
        req_rd[5*i +: 5]   = r;
        req_wd[32*i +: 32] = d;
    endtask

    initial begin
        rst = 1'b1;
        wb_stall = 1'b0;
        req_valid = 3'b111;
        req_rd = '0;
        req_wd = '0;
        #1;
        chk("rst_ready", 32'(req_ready), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        step();
        step();
        chk("rst_regwrite", 32'(RegWrite), 32'h0);
        chk("rst_rd", 32'(rd), 32'h0);
        chk("rst_wd", wd, 32'h0);
        chk("rst_gid", 32'(grant_id), 32'h0);
        rst = 1'b0;
        req_valid = 3'b000;
        step();
        chk("idle_regwrite", 32'(RegWrite), 32'h0);

        set_req(1, 5'd5, 32'hDEADBEEF);
        req_valid = 3'b010;
        #1;
        chk("single_ready", 32'(req_ready), 32'h2);
        chk("single_busy", 32'(busy), 32'h1);
        step();
        req_valid = 3'b000;
        chk("single_regwrite", 32'(RegWrite), 32'h1);
        chk("single_rd", 32'(rd), 32'd5);
        chk("single_wd", wd, 32'hDEADBEEF);
        chk("single_gid", 32'(grant_id), 32'd1);
        step();
        chk("single_drop", 32'(RegWrite), 32'h0);

        set_req(2, 5'd0, 32'h1234);
        req_valid = 3'b100;
        #1;
        chk("x0_ready", 32'(req_ready), 32'h4);
        step();
        req_valid = 3'b000;
        chk("x0_regwrite", 32'(RegWrite), 32'h0);
        chk("x0_wd", wd, 32'h1234);
        chk("x0_gid", 32'(grant_id), 32'd2);

        for (int i = 0; i < 3; i++) set_req(i, 5'(10 + i), 32'h100 + 32'(i));
        req_valid = 3'b111;
        for (int c = 0; c < 6; c++) begin
            #1;
            chk("rr_ready", 32'(req_ready), 32'(1 << (c % 3)));
            step();
            chk("rr_regwrite", 32'(RegWrite), 32'h1);
            chk("rr_gid", 32'(grant_id), 32'(c % 3));
            chk("rr_rd", 32'(rd), 32'(10 + c % 3));
        end
        step();
        step();
        chk("pre_rst_gid", 32'(grant_id), 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_ready", 32'(req_ready), 32'h0);
        chk("mid_rst_busy", 32'(busy), 32'h0);
        step();
        rst = 1'b0;
        chk("mid_rst_regwrite", 32'(RegWrite), 32'h0);
        #1;
        chk("post_rst_ready", 32'(req_ready), 32'h1);
        step();
        req_valid = 3'b000;
        chk("post_rst_gid", 32'(grant_id), 32'd0);
        chk("post_rst_regwrite", 32'(RegWrite), 32'h1);

        req_valid = 3'b100;
        step();
        req_valid = 3'b101;
        wb_stall = 1'b1;
        chk("pre_stall_gid", 32'(grant_id), 32'd2);
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("stall_ready", 32'(req_ready), 32'h0);
            chk("stall_busy", 32'(busy), 32'h0);
            step();
            chk("stall_regwrite", 32'(RegWrite), 32'h0);
        end
        wb_stall = 1'b0;
        #1;
        chk("unstall_ready0", 32'(req_ready), 32'h1);
        step();
        req_valid = 3'b100;
        chk("unstall_gid0", 32'(grant_id), 32'd0);
        #1;
        chk("unstall_ready2", 32'(req_ready), 32'h4);
        step();
        req_valid = 3'b000;
        chk("unstall_gid2", 32'(grant_id), 32'd2);
        chk("unstall_regwrite", 32'(RegWrite), 32'h1);

        set_req(0, 5'd7, 32'hAAAA0000);
        set_req(1, 5'd7, 32'h0000BBBB);
        req_valid = 3'b011;
        #1;
        chk("same_ready0", 32'(req_ready), 32'h1);
        step();
        req_valid = 3'b010;
        chk("same_w1_regwrite", 32'(RegWrite), 32'h1);
        chk("same_w1_rd", 32'(rd), 32'd7);
        chk("same_w1_wd", wd, 32'hAAAA0000);
        #1;
        chk("same_ready1", 32'(req_ready), 32'h2);
        step();
        req_valid = 3'b000;
        chk("same_w2_regwrite", 32'(RegWrite), 32'h1);
        chk("same_w2_rd", 32'(rd), 32'd7);
        chk("same_w2_wd", wd, 32'h0000BBBB);
        step();
        chk("same_reg7", regs[7], 32'h0000BBBB);
        chk("same_done", 32'(RegWrite), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-back arbiter for the 32x32 register file's single write port. Up to NREQ execution units (ALU, load unit, multiplier, …) present write-back requests on valid/ready handshakes. A round-robin arbiter grants at most one request per cycle. The winner is registered into an output stage that drives the register file's `RegWrite`/`rd`/`wd` write port one cycle later.

## Interface
- `NREQ`, default 3: number of write-back requesters; legal range 2..8.
- `GW`, default `$clog2(NREQ)`: width of `grant_id`; derived, not overridden.
- `clk` input, 1 bit: single clock; all state updates on the rising edge.
- `rst` input, 1 bit: synchronous, active-high reset.
- `req_valid` input, NREQ bits: bit i means requester i holds a write-back.
- `req_rd` input, NREQ*5 bits: destination register of requester i, in bits [5i+4:5i].
- `req_wd` input, NREQ*32 bits: write data of requester i, in bits [32i+31:32i].
- `req_ready` output, NREQ bits: one-hot or zero; bit i means requester i is accepted this cycle.
- `wb_stall` input, 1 bit: when high, no request is granted this cycle.
- `RegWrite` output, 1 bit: register-file write enable.
- `rd` output, 5 bits: register-file write address.
- `wd` output, 32 bits: register-file write data.
- `grant_id` output, GW bits: index of the requester whose write is on the output stage.
- `busy` output, 1 bit: high when any `req_valid` is high and the arbiter is not stalled.

## Operation
- Transfer: requester i transfers when `req_valid[i] && req_ready[i]` at a rising edge.
- Requester obligations: a requester holds `req_valid`, `req_rd` and `req_wd` stable until it is accepted. The arbiter never depends on a requester withdrawing.
- Grant, combinational within the cycle:
  - If `rst` or `wb_stall` is high, `req_ready` = 0.
  - Otherwise, search from index `ptr` upward, modulo NREQ. The first i with `req_valid[i]` wins, and `req_ready[i]` = 1.
  - If no request is valid, `req_ready` = 0.
- Round-robin pointer `ptr`, range 0..NREQ-1:
  - Reset value 0.
  - On a transfer by requester i, `ptr` becomes (i+1) mod NREQ.
  - Otherwise `ptr` is unchanged.
  - Wrap-around: a grant to NREQ-1 sets `ptr` to 0.
- Output stage, registered and updated every cycle:
  - On a transfer: `rd` and `wd` take the winner's values, and `grant_id` = i.
  - On a transfer, `RegWrite` = 1 unless the winner's `req_rd` == 0.
  - x0 writes are accepted (ready asserted, pointer advanced) but drive `RegWrite` = 0. `rd` and `wd` are still loaded.
  - With no transfer, `RegWrite` = 0, and `rd`, `wd` and `grant_id` hold their previous values.
- Same-destination requests: two requesters targeting the same `rd` in the same cycle are not merged. They are serialized in round-robin order, and the later grant's data is what persists in the register file.
- Fairness: a continuously valid requester is granted within NREQ cycles of `req_valid` rising, provided `wb_stall` stays low.
- `busy` = `|req_valid` && !`wb_stall` && !`rst`, combinational.

## Timing
- Reset: while `rst` is high at a rising edge, the following hold after that edge:
  - `RegWrite` = 0, `rd` = 0, `wd` = 0, `grant_id` = 0, `ptr` = 0.
  - `req_ready` = 0 throughout the reset cycle.
- Reset mid-operation: a request presented during the reset cycle is not accepted and is not written. The requester keeps it valid and is granted after `rst` falls, searching from `ptr` = 0.
- Latency: a transfer at edge N gives `RegWrite`/`rd`/`wd` valid during cycle N+1. The register file commits the write at edge N+1.
- Throughput: one write per cycle. Back-to-back grants to different requesters, or to the same requester with a new transaction, are allowed on consecutive cycles.
- Stall: `wb_stall` high in cycle N means no transfer at edge N and `RegWrite` = 0 in cycle N+1. `ptr` is unchanged. Pending requests are not lost.
- Stall/valid simultaneity: `wb_stall` takes precedence over all `req_valid`.
- Combinational paths: `req_ready` depends on `req_valid`, `wb_stall`, `rst` and `ptr`. There is no combinational path from the request inputs to `RegWrite`/`rd`/`wd`.

## Test plan
- Reset, then single request:
  - Stimulus: after reset, `req_valid` = 3'b010, rd = 5, wd = 0xDEADBEEF.
  - Required: `req_ready` = 3'b010 in the same cycle.
  - Required next cycle: `RegWrite` = 1, `rd` = 5, `wd` = 0xDEADBEEF, `grant_id` = 1; then `RegWrite` = 0.
- All three requesters held valid for 6 cycles from `ptr` = 0:
  - Required grant order: 0, 1, 2, 0, 1, 2.
  - Required `RegWrite` high for 6 consecutive cycles, lagging the grants by 1 cycle.
- x0 write:
  - Stimulus: requester 2 writes rd = 0, wd = 0x1234.
  - Required: `req_ready[2]` = 1, `ptr` becomes 0, and next-cycle `RegWrite` = 0.
- Stall:
  - Stimulus: `req_valid` = 3'b101 with `wb_stall` high for 3 cycles.
  - Required during the stall: `req_ready` = 0, `RegWrite` = 0, `busy` = 0.
  - Required after the stall drops: requester 0 granted first (`ptr` = 0), then requester 2.
- Reset mid-stream:
  - Stimulus: during the round-robin test, `rst` asserted for 1 cycle while `ptr` = 2.
  - Required: no grant in the reset cycle; after reset, `RegWrite` = 0 and requester 0 is granted first.
- Same-rd conflict:
  - Stimulus: requesters 0 and 1 both target rd = 7 with 0xAAAA0000 and 0x0000BBBB, `ptr` = 0.
  - Required: two consecutive writes to 7, 0xAAAA0000 then 0x0000BBBB; register 7 reads 0x0000BBBB afterwards.
